// File: rtl/seq_pattern_tx_pkg.sv
// rtl/seq_pattern_tx_pkg.sv - shared constants and state encodings for seq_pattern_tx
package seq_pattern_pkg;

  localparam int SEQ_PAT_W_DEF = 5;
  localparam int SEQ_CNT_W_DEF = 4;

  localparam logic [SEQ_PAT_W_DEF-1:0] SEQ_DEFAULT_PATTERN = 5'b10101;

  localparam int SEQ_BIT_IDX_W = $clog2(SEQ_PAT_W_DEF);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // Bit-index width for an arbitrary pattern width, never narrower than one bit
  function automatic int seq_idx_w(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - control and serial-output bundle of seq_pattern_tx
interface seq_pattern_tx_if
  import seq_pattern_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W_DEF,
  parameter int CNT_W = SEQ_CNT_W_DEF
);

  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             start;
  logic [CNT_W-1:0] rep;
  logic             seq_out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output load, pat_in, start, rep,
    input  seq_out, valid, busy, done
  );

  modport slave (
    input  load, pat_in, start, rep,
    output seq_out, valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, MSB first, REP repeats; SEQ_PATTERN_TX_GAP_EN adds an idle cycle between repeats
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_DEFAULT_PATTERN,
  parameter int               CNT_W   = SEQ_CNT_W_DEF
)(
  input logic               clk,
  input logic               arstn,
  seq_pattern_tx_if.slave   bus
);

  localparam int             IW       = seq_idx_w(PAT_W);
  localparam logic [IW-1:0]  LAST_IDX = IW'(PAT_W - 1);

  logic [1:0]       r_state;
  logic [IW-1:0]    r_bit_idx;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [PAT_W-1:0] r_pat;
  logic             r_seq_out;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic w_last_bit;
  logic w_last_rep;

  assign w_last_bit = (r_bit_idx == '0);
  assign w_last_rep = (r_rep_cnt == CNT_W'(1));

  // Sequencer: walks bit index and repeat count, start is honoured only in IDLE
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_rep_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.rep != '0) begin
              r_rep_cnt <= bus.rep;
              r_bit_idx <= LAST_IDX;
              r_state   <= ST_SHIFT;
            end else begin
              r_state   <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_rep_cnt <= r_rep_cnt - CNT_W'(1);
            if (w_last_rep) begin
              r_state <= ST_DONE;
            end else begin
              r_bit_idx <= LAST_IDX;
`ifdef SEQ_PATTERN_TX_GAP_EN
              r_state   <= ST_GAP;
`endif
            end
          end else begin
            r_bit_idx <= r_bit_idx - IW'(1);
          end
        end
`ifdef SEQ_PATTERN_TX_GAP_EN
        ST_GAP: begin
          r_state <= ST_SHIFT;
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pattern register: writable only while idle so a transmission sees a frozen pattern
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_pat <= PATTERN;
    end else if ((r_state == ST_IDLE) && bus.load) begin
      r_pat <= bus.pat_in;
    end
  end

  // Output stage: registered view of the current state, one cycle behind the sequencer
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_seq_out <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_seq_out <= (r_state == ST_SHIFT) && r_pat[r_bit_idx];
      r_valid   <= (r_state == ST_SHIFT);
      r_busy    <= (r_state == ST_SHIFT) || (r_state == ST_GAP);
      r_done    <= (r_state == ST_DONE);
    end
  end

  assign bus.seq_out = r_seq_out;
  assign bus.valid   = r_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - randomized self-checking bench for seq_pattern_tx against a trace model
module tb_seq_pattern_tx;
  import seq_pattern_pkg::*;

  localparam int               PAT_W   = 5;
  localparam int               CNT_W   = 4;
  localparam logic [PAT_W-1:0] RST_PAT = 5'b10101;

  logic clk = 1'b0;
  logic arstn = 1'b0;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(
    .PAT_W   (PAT_W),
    .PATTERN (RST_PAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [PAT_W-1:0] m_pat;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // {valid, seq_out, busy, done}
  function automatic logic [7:0] outs();
    return {4'b0, bus.valid, bus.seq_out, bus.busy, bus.done};
  endfunction

  // One transaction from IDLE; enters and leaves at a negedge with the DUT idle.
  // inj_start / inj_load: loop index before whose edge a stray start/load is driven (-1 = none)
  task automatic run_tx(input string name, input logic do_load, input logic [PAT_W-1:0] pat,
                        input int rep, input int inj_start, input int inj_load,
                        input logic [PAT_W-1:0] inj_pat);
    logic [7:0] exp_q[$];
    if (do_load) m_pat = pat;
    for (int r = 0; r < rep; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({4'b0, 1'b1, m_pat[b], 1'b1, 1'b0});
`ifdef SEQ_PATTERN_TX_GAP_EN
      if (r < rep - 1) exp_q.push_back(8'b0010);
`endif
    end
    exp_q.push_back(8'b0001);
    exp_q.push_back(8'b0000);

    bus.load   = do_load;
    bus.pat_in = pat;
    bus.start  = 1'b1;
    bus.rep    = CNT_W'(rep);
    @(posedge clk);
    @(negedge clk);
    bus.load   = 1'b0;
    bus.start  = 1'b0;
    bus.rep    = CNT_W'($urandom);
    bus.pat_in = PAT_W'($urandom);
    chk($sformatf("%s/lat", name), outs(), 8'h00);

    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == inj_start) begin
        bus.start = 1'b1;
        bus.rep   = CNT_W'($urandom_range(1, 15));
      end
      if (i == inj_load) begin
        bus.load   = 1'b1;
        bus.pat_in = inj_pat;
      end
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.load  = 1'b0;
      chk($sformatf("%s/c%0d", name, i), outs(), exp_q[i]);
    end
  endtask

  initial begin
    int rep;
    int span;
    int is;
    int il;
    logic ld;

    bus.load   = 1'b0;
    bus.pat_in = '0;
    bus.start  = 1'b0;
    bus.rep    = '0;
    m_pat      = RST_PAT;

    @(negedge clk);
    chk("rst", outs(), 8'h00);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    chk("rst_rel", outs(), 8'h00);

    run_tx("default",   1'b0, '0,       1,  -1, -1, '0);
    run_tx("rep3",      1'b0, '0,       3,  -1, -1, '0);
    run_tx("rep0",      1'b0, '0,       0,  -1, -1, '0);
    run_tx("load",      1'b1, 5'b11001, 1,  -1, -1, '0);
    run_tx("load_shft", 1'b0, '0,       2,  -1,  3, 5'b00111);
    run_tx("after_ld",  1'b0, '0,       1,  -1, -1, '0);
    run_tx("busy_prot", 1'b0, '0,       1,   3, -1, '0);
    run_tx("ld_start",  1'b1, 5'b01110, 2,  -1, -1, '0);
    run_tx("rep_max",   1'b0, '0,       15, -1, -1, '0);

    // Reset during the second bit of a transmission
    bus.start = 1'b1;
    bus.rep   = CNT_W'(1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid/bit1", outs(), {4'b0, 1'b1, m_pat[4], 1'b1, 1'b0});
    @(posedge clk);
    @(negedge clk);
    chk("mid/bit2", outs(), {4'b0, 1'b1, m_pat[3], 1'b1, 1'b0});
    #1 arstn = 1'b0;
    #1 chk("mid/async", outs(), 8'h00);
    m_pat = RST_PAT;
    @(negedge clk);
    chk("mid/held", outs(), 8'h00);
    arstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid/nodone%0d", i), outs(), 8'h00);
    end
    run_tx("post_rst", 1'b0, '0, 1, -1, -1, '0);

    // Randomized transactions with stray start/load during the transmission
    for (int t = 0; t < 25; t++) begin
      rep = (t == 0) ? 15 : $urandom_range(0, 15);
      ld  = 1'($urandom_range(0, 1));
`ifdef SEQ_PATTERN_TX_GAP_EN
      span = (rep == 0) ? 0 : rep * PAT_W + rep - 1;
`else
      span = rep * PAT_W;
`endif
      is = (span > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, span - 1) : -1;
      il = (span > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, span - 1) : -1;
      run_tx($sformatf("rnd%0d", t), ld, PAT_W'($urandom), rep, is, il, PAT_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
